// File: rtl/min_max_pkg.sv
// Shared types and constants for the min_max LED-bar decoder.
package min_max_pkg;

    localparam int unsigned DefValSize = 4;
    localparam int unsigned DefBarW    = 2 ** DefValSize;

    typedef logic [DefValSize-1:0] val_t;
    typedef logic [DefBarW-1:0]    bar_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitB,
        StScan,
        StOut
    } dec_state_t;

    // Error causes, used to label diagnostic messages.
    localparam int unsigned ErrNone       = 0;
    localparam int unsigned ErrFullEmpty  = 1;
    localparam int unsigned ErrFullBroken = 2;
    localparam int unsigned ErrLitEmpty   = 3;
    localparam int unsigned ErrLitBroken  = 4;
    localparam int unsigned ErrLitOffset  = 5;

endpackage

// File: rtl/min_max_dec_scan.sv
// Serial scanner: walks the merged bars one bit per cycle, tracking run bounds and breaks.
module min_max_dec_scan
    import min_max_pkg::*;
#(
    parameter int unsigned VALSIZE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [2**VALSIZE-1:0] full_i,
    input  logic [2**VALSIZE-1:0] lit_i,
    output logic                  done_o,
    output logic [VALSIZE-1:0]    first_o,
    output logic [VALSIZE-1:0]    last_o,
    output logic [VALSIZE-1:0]    lit_last_o,
    output logic                  err_o
);

    localparam int unsigned N = 2 ** VALSIZE;

    logic               busy_q, busy_d;
    logic [VALSIZE:0]   idx_q, idx_d;
    logic               have_full_q, have_full_d;
    logic               have_lit_q, have_lit_d;
    logic               brk_q, brk_d;
    logic [VALSIZE-1:0] first_q, first_d;
    logic [VALSIZE-1:0] last_q, last_d;
    logic [VALSIZE-1:0] lit_first_q, lit_first_d;
    logic [VALSIZE-1:0] lit_last_q, lit_last_d;
    logic [VALSIZE-1:0] bit_idx;

    assign bit_idx = idx_q[VALSIZE-1:0];
    assign done_o  = busy_q && (idx_q == (VALSIZE+1)'(N));

    always_comb begin
        busy_d      = busy_q;
        idx_d       = idx_q;
        have_full_d = have_full_q;
        have_lit_d  = have_lit_q;
        brk_d       = brk_q;
        first_d     = first_q;
        last_d      = last_q;
        lit_first_d = lit_first_q;
        lit_last_d  = lit_last_q;
        if (start_i) begin
            busy_d      = 1'b1;
            idx_d       = '0;
            have_full_d = 1'b0;
            have_lit_d  = 1'b0;
            brk_d       = 1'b0;
            first_d     = '0;
            last_d      = '0;
            lit_first_d = '0;
            lit_last_d  = '0;
        end else if (busy_q) begin
            if (done_o) begin
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
                if (full_i[bit_idx]) begin
                    if (!have_full_q) begin
                        have_full_d = 1'b1;
                        first_d     = bit_idx;
                    end else if (last_q + 1'b1 != bit_idx) begin
                        brk_d = 1'b1;
                    end
                    last_d = bit_idx;
                end
                if (lit_i[bit_idx]) begin
                    if (!have_lit_q) begin
                        have_lit_d  = 1'b1;
                        lit_first_d = bit_idx;
                    end else if (lit_last_q + 1'b1 != bit_idx) begin
                        brk_d = 1'b1;
                    end
                    lit_last_d = bit_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q      <= 1'b0;
            idx_q       <= '0;
            have_full_q <= 1'b0;
            have_lit_q  <= 1'b0;
            brk_q       <= 1'b0;
            first_q     <= '0;
            last_q      <= '0;
            lit_first_q <= '0;
            lit_last_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            have_full_q <= have_full_d;
            have_lit_q  <= have_lit_d;
            brk_q       <= brk_d;
            first_q     <= first_d;
            last_q      <= last_d;
            lit_first_q <= lit_first_d;
            lit_last_q  <= lit_last_d;
        end
    end

    assign first_o    = first_q;
    assign last_o     = last_q;
    assign lit_last_o = lit_last_q;
    // lit is a subset of full, so a lit run must begin exactly where the full run does.
    assign err_o      = !have_full_q || !have_lit_q || brk_q || (lit_first_q != first_q);

endmodule

// File: rtl/min_max_decoder.sv
// Recovers (min, max, value) from two opposite-phase LED frames of min_max_top.
module min_max_decoder
    import min_max_pkg::*;
#(
    parameter int unsigned VALSIZE = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [2**VALSIZE-1:0] leds_i,
    input  logic                  leds_valid_i,
    output logic                  leds_ready_o,
    output logic [VALSIZE-1:0]    min_o,
    output logic [VALSIZE-1:0]    max_o,
    output logic [VALSIZE-1:0]    value_o,
    output logic                  err_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i
);

    localparam int unsigned N    = 2 ** VALSIZE;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    dec_state_t         state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [VALSIZE-1:0] min_q, min_d;
    logic [VALSIZE-1:0] max_q, max_d;
    logic [VALSIZE-1:0] val_q, val_d;
    logic               err_q, err_d;

    logic               frame_xfer;
    logic               scan_start;
    logic               scan_done;
    logic               scan_err;
    logic [VALSIZE-1:0] scan_first;
    logic [VALSIZE-1:0] scan_last;
    logic [VALSIZE-1:0] scan_lit_last;
    logic [N-1:0]       full;
    logic [N-1:0]       lit;

    assign full         = a_q | b_q;
    assign lit          = a_q & b_q;
    assign leds_ready_o = (state_q == StIdle) || (state_q == StWaitB);
    assign frame_xfer   = leds_valid_i && leds_ready_o;

    min_max_dec_scan #(
        .VALSIZE(VALSIZE)
    ) u_scan (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (scan_start),
        .full_i     (full),
        .lit_i      (lit),
        .done_o     (scan_done),
        .first_o    (scan_first),
        .last_o     (scan_last),
        .lit_last_o (scan_lit_last),
        .err_o      (scan_err)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        val_d      = val_q;
        err_d      = err_q;
        scan_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_xfer) begin
                    a_d     = leds_i;
                    cnt_d   = '0;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (frame_xfer) begin
                    b_d        = leds_i;
                    scan_start = 1'b1;
                    state_d    = StScan;
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    a_d     = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StScan: begin
                if (scan_done) begin
                    err_d   = scan_err;
                    min_d   = scan_err ? '0 : scan_first;
                    max_d   = scan_err ? '0 : scan_last;
                    val_d   = scan_err ? '0 : scan_lit_last;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    // Result fields read as zero whenever no result is being offered.
    assign res_valid_o = (state_q == StOut);
    assign min_o       = res_valid_o ? min_q : '0;
    assign max_o       = res_valid_o ? max_q : '0;
    assign value_o     = res_valid_o ? val_q : '0;
    assign err_o       = res_valid_o ? err_q : 1'b0;

endmodule

// File: tb/tb_min_max_decoder.sv
// Directed bench for min_max_decoder (VALSIZE=4, TIMEOUT=15).
module tb_min_max_decoder;

    logic        clk;
    logic        rst_ni;
    logic [15:0] leds;
    logic        leds_valid;
    logic        leds_ready;
    logic [3:0]  min_v;
    logic [3:0]  max_v;
    logic [3:0]  val_v;
    logic        err;
    logic        res_valid;
    logic        res_ready;

    int total;
    int bad;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  mn;
        logic [3:0]  mx;
        logic [3:0]  v;
        logic        e;
    } vec_t;

    min_max_decoder #(
        .VALSIZE(4),
        .TIMEOUT(15)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .leds_i       (leds),
        .leds_valid_i (leds_valid),
        .leds_ready_o (leds_ready),
        .min_o        (min_v),
        .max_o        (max_v),
        .value_o      (val_v),
        .err_o        (err),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one frame until accepted; returns 1 ns after the accepting edge.
    task automatic send_frame(input logic [15:0] f);
        int guard;
        guard = 0;
        leds       = f;
        leds_valid = 1'b1;
        while (!leds_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        leds_valid = 1'b0;
        leds       = '0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        total++;
        if (leds_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", leds_ready);
        end
        total++;
        if ({res_valid, err, min_v, max_v, val_v} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%0d/%0d/%0d exp=all zero",
                     res_valid, err, min_v, max_v, val_v);
        end
    endtask

    task automatic test_decode();
        vec_t vecs[10];
        int   lat;
        vecs = '{
            '{16'h1FF8, 16'h01F8, 4'd3,  4'd12, 4'd8,  1'b0},
            '{16'h01F8, 16'h1FF8, 4'd3,  4'd12, 4'd8,  1'b0},
            '{16'hFFFF, 16'hFFFF, 4'd0,  4'd15, 4'd15, 1'b0},
            '{16'h0F0F, 16'h000F, 4'd0,  4'd0,  4'd0,  1'b1},
            '{16'h0000, 16'h0000, 4'd0,  4'd0,  4'd0,  1'b1},
            '{16'h0010, 16'h0010, 4'd4,  4'd4,  4'd4,  1'b0},
            '{16'h00F0, 16'h00C0, 4'd0,  4'd0,  4'd0,  1'b1},
            '{16'h0018, 16'h0000, 4'd0,  4'd0,  4'd0,  1'b1},
            '{16'h8000, 16'h8000, 4'd15, 4'd15, 4'd15, 1'b0},
            '{16'h0001, 16'h0003, 4'd0,  4'd1,  4'd0,  1'b0}
        };
        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].a);
            send_frame(vecs[i].b);
            wait_result(lat);
            total++;
            if (lat !== 17) begin
                bad++;
                $display("FAIL dec%0d_latency got=%0d exp=17", i, lat);
            end
            total++;
            if ({err, min_v, max_v, val_v} !== {vecs[i].e, vecs[i].mn, vecs[i].mx, vecs[i].v}) begin
                bad++;
                $display("FAIL dec%0d_result got=err%b %0d/%0d/%0d exp=err%b %0d/%0d/%0d",
                         i, err, min_v, max_v, val_v,
                         vecs[i].e, vecs[i].mn, vecs[i].mx, vecs[i].v);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            total++;
            if (res_valid !== 1'b0 || leds_ready !== 1'b1) begin
                bad++;
                $display("FAIL dec%0d_release got=valid%b ready%b exp=valid0 ready1",
                         i, res_valid, leds_ready);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        send_frame(16'h1FF8);
        send_frame(16'h01F8);
        wait_result(lat);
        // Junk frame offered while busy must be ignored.
        leds       = 16'h5555;
        leds_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({res_valid, leds_ready, err, min_v, max_v, val_v} !==
                {1'b1, 1'b0, 1'b0, 4'd3, 4'd12, 4'd8}) begin
                bad++;
                $display("FAIL hold%0d got=valid%b ready%b err%b %0d/%0d/%0d exp=valid1 ready0 err0 3/12/8",
                         c, res_valid, leds_ready, err, min_v, max_v, val_v);
            end
        end
        leds_valid = 1'b0;
        leds       = '0;
        res_ready  = 1'b1;
        tick();
        res_ready  = 1'b0;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_timeout();
        int lat;
        int seen;
        // 15 idle cycles: still waiting, next frame is B.
        send_frame(16'h1FF8);
        repeat (15) tick();
        send_frame(16'h01F8);
        wait_result(lat);
        total++;
        if (lat !== 17 || {err, min_v, max_v, val_v} !== {1'b0, 4'd3, 4'd12, 4'd8}) begin
            bad++;
            $display("FAIL tmo15 got=lat%0d err%b %0d/%0d/%0d exp=lat17 err0 3/12/8",
                     lat, err, min_v, max_v, val_v);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        // 16 idle cycles: A is abandoned, next frame starts a new pair.
        send_frame(16'h1FF8);
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (res_valid) seen++;
        end
        total++;
        if (seen !== 0 || leds_ready !== 1'b1) begin
            bad++;
            $display("FAIL tmo16_idle got=valid_cycles%0d ready%b exp=0 ready1", seen, leds_ready);
        end
        send_frame(16'h0010);
        send_frame(16'h0010);
        wait_result(lat);
        total++;
        if (lat !== 17 || {err, min_v, max_v, val_v} !== {1'b0, 4'd4, 4'd4, 4'd4}) begin
            bad++;
            $display("FAIL tmo16_newpair got=lat%0d err%b %0d/%0d/%0d exp=lat17 err0 4/4/4",
                     lat, err, min_v, max_v, val_v);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        send_frame(16'hFFFF);
        send_frame(16'hFFFF);
        repeat (5) tick();
        rst_ni = 1'b0;
        tick();
        total++;
        if ({res_valid, leds_ready, err, min_v, max_v, val_v} !== {1'b0, 1'b1, 13'd0}) begin
            bad++;
            $display("FAIL rst_scan got=valid%b ready%b err%b %0d/%0d/%0d exp=valid0 ready1 zeros",
                     res_valid, leds_ready, err, min_v, max_v, val_v);
        end
        rst_ni = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (res_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_no_partial got=valid_cycles%0d exp=0", seen);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_ni     = 1'b0;
        leds       = '0;
        leds_valid = 1'b0;
        res_ready  = 1'b0;
        test_reset();
        test_decode();
        test_hold();
        test_timeout();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
